alu_mc: RTL

Parametrised multi-cycle execute-stage ALU for the pipelined MIPS core. It replaces the purely combinational ALU with a valid/ready unit. Single-cycle ops (ADD/SUB/logic/compare) complete with 1-cycle registered latency. MUL/MULU/DIV/DIVU run an iterative shift-add / restoring-divide datapath and return a 2×WIDTH result split into HI/LO. The execute stage stalls on `in_ready`/`out_valid`; the hazard unit kills in-flight ops with `flush`.

---
 rtl/alu_mc_if.sv | 28 ++
 rtl/alu_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle between the execute stage and alu_mc.
// The execute stage (master) drives operands and consumes results; the ALU is the slave.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control_opr;
    logic [WIDTH-1:0] src_a_e;
    logic [WIDTH-1:0] src_b_e;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out_lo;
    logic [WIDTH-1:0] alu_out_hi;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output flush, in_valid, alu_control_opr, src_a_e, src_b_e, out_ready,
        input  in_ready, out_valid, alu_out_lo, alu_out_hi, div_by_zero, busy
    );

    modport slave (
        input  flush, in_valid, alu_control_opr, src_a_e, src_b_e, out_ready,
        output in_ready, out_valid, alu_out_lo, alu_out_hi, div_by_zero, busy
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshake.
// Single-cycle ops register their result at the accept edge. MUL/MULU run a
// shift-add loop and DIV/DIVU a restoring divide on unsigned magnitudes, one
// step per cycle, followed by a FIX cycle that applies the sign correction.
module alu_mc #(
    parameter int WIDTH    = 32,
    parameter int CNT_BITS = $clog2(WIDTH + 1)
) (
    input  logic  clk,
    input  logic  reset_n,
    alu_mc_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOR  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_MULU = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic [CNT_BITS-1:0]  cnt_q;
    // Working register: {hi, lo}. MUL: {partial product, multiplier}.
    // DIV: {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0]   pr_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     a_raw_q;
    logic                 is_div_q;
    logic                 neg_q;
    logic                 rem_neg_q;
    logic                 dz_pend_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     hi_q;
    logic                 dz_q;
    logic                 out_valid_q;
    logic                 busy_q;

    logic                 in_ready_s;
    logic                 accept_s;
    logic [WIDTH-1:0]     sc_lo_s;
    logic                 is_multi_s;
    logic                 is_signed_s;
    logic                 is_div_s;
    logic                 sign_a_s;
    logic                 sign_b_s;
    logic [WIDTH-1:0]     mag_a_s;
    logic [WIDTH-1:0]     mag_b_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH-1:0]     diff_s;
    logic [2*WIDTH-1:0]   pr_d;
    logic [2*WIDTH-1:0]   prod_neg_s;
    logic [WIDTH-1:0]     fix_lo_s;
    logic [WIDTH-1:0]     fix_hi_s;

    // Ready is held low in reset and while a flush is being applied.
    assign in_ready_s = reset_n && !bus.flush &&
                        ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
    assign accept_s   = bus.in_valid && in_ready_s;

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_q;
    assign bus.alu_out_lo  = lo_q;
    assign bus.alu_out_hi  = hi_q;
    assign bus.div_by_zero = dz_q;
    assign bus.busy        = busy_q;

    // Decode the opcode and compute the single-cycle result and operand magnitudes.
    always_comb begin
        sc_lo_s     = {WIDTH{1'b0}};
        is_multi_s  = 1'b0;
        is_signed_s = 1'b0;
        is_div_s    = 1'b0;
        case (bus.alu_control_opr)
            OP_ADD:  sc_lo_s = bus.src_a_e + bus.src_b_e;
            OP_SUB:  sc_lo_s = bus.src_a_e - bus.src_b_e;
            OP_AND:  sc_lo_s = bus.src_a_e & bus.src_b_e;
            OP_OR:   sc_lo_s = bus.src_a_e | bus.src_b_e;
            OP_XOR:  sc_lo_s = bus.src_a_e ^ bus.src_b_e;
            OP_NOR:  sc_lo_s = ~(bus.src_a_e | bus.src_b_e);
            OP_SLT:  sc_lo_s = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a_e) < $signed(bus.src_b_e))};
            OP_SLTU: sc_lo_s = {{(WIDTH-1){1'b0}}, (bus.src_a_e < bus.src_b_e)};
            OP_MUL:  begin is_multi_s = 1'b1; is_signed_s = 1'b1; end
            OP_MULU: begin is_multi_s = 1'b1; end
            OP_DIV:  begin is_multi_s = 1'b1; is_signed_s = 1'b1; is_div_s = 1'b1; end
            OP_DIVU: begin is_multi_s = 1'b1; is_div_s = 1'b1; end
            default: sc_lo_s = {WIDTH{1'b0}};
        endcase
        sign_a_s = is_signed_s && bus.src_a_e[WIDTH-1];
        sign_b_s = is_signed_s && bus.src_b_e[WIDTH-1];
        if (sign_a_s) begin
            mag_a_s = {WIDTH{1'b0}} - bus.src_a_e;
        end else begin
            mag_a_s = bus.src_a_e;
        end
        if (sign_b_s) begin
            mag_b_s = {WIDTH{1'b0}} - bus.src_b_e;
        end else begin
            mag_b_s = bus.src_b_e;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        if (pr_q[0]) begin
            mul_sum_s = {1'b0, pr_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        end else begin
            mul_sum_s = {1'b0, pr_q[2*WIDTH-1:WIDTH]};
        end
        rem_sh_s = {pr_q[2*WIDTH-1:WIDTH], pr_q[WIDTH-1]};
        diff_s   = rem_sh_s[WIDTH-1:0] - b_q;
        if (!is_div_q) begin
            pr_d = {mul_sum_s, pr_q[WIDTH-1:1]};
        end else if (rem_sh_s >= {1'b0, b_q}) begin
            pr_d = {diff_s, pr_q[WIDTH-2:0], 1'b1};
        end else begin
            pr_d = {rem_sh_s[WIDTH-1:0], pr_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction and divide-by-zero override applied in the FIX state.
    always_comb begin
        prod_neg_s = {(2*WIDTH){1'b0}} - pr_q;
        fix_lo_s   = pr_q[WIDTH-1:0];
        fix_hi_s   = pr_q[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            if (neg_q) begin
                fix_lo_s = prod_neg_s[WIDTH-1:0];
                fix_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
            end else begin
                fix_lo_s = pr_q[WIDTH-1:0];
                fix_hi_s = pr_q[2*WIDTH-1:WIDTH];
            end
        end else if (dz_pend_q) begin
            fix_lo_s = {WIDTH{1'b1}};
            fix_hi_s = a_raw_q;
        end else begin
            if (neg_q) begin
                fix_lo_s = {WIDTH{1'b0}} - pr_q[WIDTH-1:0];
            end else begin
                fix_lo_s = pr_q[WIDTH-1:0];
            end
            if (rem_neg_q) begin
                fix_hi_s = {WIDTH{1'b0}} - pr_q[2*WIDTH-1:WIDTH];
            end else begin
                fix_hi_s = pr_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Control FSM with registered result, valid and busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_BITS{1'b0}};
            pr_q        <= {(2*WIDTH){1'b0}};
            b_q         <= {WIDTH{1'b0}};
            a_raw_q     <= {WIDTH{1'b0}};
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            dz_pend_q   <= 1'b0;
            lo_q        <= {WIDTH{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_BITS{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        if (is_multi_s) begin
                            pr_q        <= {{WIDTH{1'b0}}, mag_a_s};
                            b_q         <= mag_b_s;
                            a_raw_q     <= bus.src_a_e;
                            is_div_q    <= is_div_s;
                            neg_q       <= sign_a_s ^ sign_b_s;
                            rem_neg_q   <= sign_a_s;
                            dz_pend_q   <= is_div_s && (bus.src_b_e == {WIDTH{1'b0}});
                            cnt_q       <= CNT_INIT;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_RUN;
                        end else begin
                            lo_q        <= sc_lo_s;
                            hi_q        <= {WIDTH{1'b0}};
                            dz_q        <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end else if ((state_q == ST_DONE) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q     <= state_q;
                    end
                end
                ST_RUN: begin
                    pr_q  <= pr_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_FIX;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    lo_q        <= fix_lo_s;
                    hi_q        <= fix_hi_s;
                    dz_q        <= dz_pend_q;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= ST_DONE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule
